// File: rtl/sprite_pkg.sv
// Shared types for the sprite fetch path: vram word layout and RGB444 colour.
package sprite_pkg;

  typedef logic [11:0] rgb444_t;

  localparam int TRANSPARENT_BIT = 12;

  typedef struct packed {
    logic    transparent;
    rgb444_t color;
  } sprite_word_t;

  // Colour seen by the compositor: black whenever there is no opaque sprite pixel.
  function automatic rgb444_t visible_color(input sprite_word_t word, input logic in_box);
    rgb444_t result;
    if (in_box && !word.transparent) begin
      result = word.color;
    end else begin
      result = 12'h000;
    end
    return result;
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation counter: steps the sprite-sheet frame once every FRAME_TICKS enabled display frames.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int FRAMES      = 8,
  parameter int FRAME_TICKS = 6,
  parameter int FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] frame
);

  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [TICK_W-1:0]  tick_r;
  logic [FRAME_W-1:0] frame_r;

  // Tick/frame counter; frame wraps naturally because FRAMES is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r  <= '0;
      frame_r <= '0;
    end else if (frame_start && anim_en) begin
      if (tick_r == TICK_W'(FRAME_TICKS - 1)) begin
        tick_r  <= '0;
        frame_r <= frame_r + FRAME_W'(1);
      end else begin
        tick_r  <= tick_r + TICK_W'(1);
      end
    end
  end

  assign frame = frame_r;

endmodule

// File: rtl/sprite_fetch.sv
// Per-pixel sprite fetch: bounding-box test, vram address generation and
// transparent-aware colour output at a fixed latency of 3 cycles.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int FRAMES      = 8,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [X_WIDTH-1:0]    sprite_x,
  input  logic [Y_WIDTH-1:0]    sprite_y,
  input  logic                  anim_en,
  input  logic                  pix_valid,
  input  logic [X_WIDTH-1:0]    pix_x,
  input  logic [Y_WIDTH-1:0]    pix_y,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  output logic                  out_hit,
  output logic [11:0]           out_color
);

  localparam int COL_W   = $clog2(SPR_W);
  localparam int ROW_W   = $clog2(SPR_H);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [X_WIDTH-1:0]    pos_x_r;
  logic [Y_WIDTH-1:0]    pos_y_r;
  logic [FRAME_W-1:0]    frame_s;
  logic [X_WIDTH:0]      x_end_s;
  logic [Y_WIDTH:0]      y_end_s;
  logic                  in_box_s;
  logic [COL_W-1:0]      col_s;
  logic [ROW_W-1:0]      row_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  valid_d1_r;
  logic                  valid_d2_r;
  logic                  in_box_d2_r;
  sprite_word_t          word_s;

  sprite_anim_ctr #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FRAME_W     (FRAME_W)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .frame       (frame_s)
  );

  // Sprite position latch, updated once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_r <= '0;
      pos_y_r <= '0;
    end else if (frame_start) begin
      pos_x_r <= sprite_x;
      pos_y_r <= sprite_y;
    end
  end

  // Box test at one extra bit so a sprite hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    x_end_s  = {1'b0, pos_x_r} + (X_WIDTH + 1)'(SPR_W);
    y_end_s  = {1'b0, pos_y_r} + (Y_WIDTH + 1)'(SPR_H);
    in_box_s = pix_valid
               && ({1'b0, pix_x} >= {1'b0, pos_x_r}) && ({1'b0, pix_x} < x_end_s)
               && ({1'b0, pix_y} >= {1'b0, pos_y_r}) && ({1'b0, pix_y} < y_end_s);
    col_s    = COL_W'(pix_x - pos_x_r);
    row_s    = ROW_W'(pix_y - pos_y_r);
    if (in_box_s) begin
      addr_s = ADDR_WIDTH'({frame_s, row_s, col_s});
    end else begin
      addr_s = '0;
    end
  end

  // Address stage plus the delay line that lines the valid/in-box flags up with rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      valid_d1_r  <= 1'b0;
      valid_d2_r  <= 1'b0;
      in_box_d2_r <= 1'b0;
    end else begin
      rom_en      <= in_box_s;
      rom_addr    <= addr_s;
      valid_d1_r  <= pix_valid;
      valid_d2_r  <= valid_d1_r;
      in_box_d2_r <= rom_en;
    end
  end

  assign word_s = sprite_word_t'(rom_data[TRANSPARENT_BIT:0]);

  // Output stage; the in-box gate matters because a disabled vram returns opaque black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= 12'h000;
    end else begin
      out_valid <= valid_d2_r;
      out_hit   <= in_box_d2_r && !word_s.transparent;
      out_color <= visible_color(word_s, in_box_d2_r);
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a one-cycle-latency vram stand-in.
module tb_sprite_fetch;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        anim_en;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        rom_en;
  logic [14:0] rom_addr;
  logic [12:0] rom_data;
  logic        out_valid;
  logic        out_hit;
  logic [11:0] out_color;

  int          n_tests;
  int          n_fail;
  logic [12:0] pend;
  logic [12:0] fixed_word;
  logic        use_pattern;

  sprite_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .anim_en     (anim_en),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_hit     (out_hit),
    .out_color   (out_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; vram answers one cycle after each read.
  task automatic tick();
    @(negedge clk);
    rom_data = pend;
    if (rom_en) pend = use_pattern ? {1'b0, rom_addr[11:0]} : fixed_word;
    else        pend = 13'h0000;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".en"},    32'(rom_en),    32'd0);
    chk({tag, ".addr"},  32'(rom_addr),  32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".hit"},   32'(out_hit),   32'd0);
    chk({tag, ".color"}, 32'(out_color), 32'd0);
  endtask

  task automatic pixel(input string tag, input logic v, input int x, input int y,
                       input logic exp_en, input int exp_addr, input logic exp_hit, input int exp_color);
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y);
    tick();
    chk({tag, ".en"},   32'(rom_en),   32'(exp_en));
    chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    pix_valid = 1'b0;
    tick();
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".hit"},   32'(out_hit),   32'(exp_hit));
    chk({tag, ".color"}, 32'(out_color), 32'(exp_color));
  endtask

  task automatic fstart(input int x, input int y, input logic a);
    frame_start = 1'b1; sprite_x = 10'(x); sprite_y = 10'(y); anim_en = a;
    tick();
    frame_start = 1'b0; anim_en = 1'b0;
  endtask

  // Back-to-back in-box pixels (x = c, y = 2); optional async reset at iteration rst_at.
  task automatic stream(input string tag, input int n, input int base, input int rst_at);
    for (int c = 0; c < n + 2; c++) begin
      pix_valid = (c < n); pix_x = 10'(c); pix_y = 10'd2;
      tick();
      if (c < n) begin
        chk($sformatf("%s.en%0d", tag, c),   32'(rom_en),   32'd1);
        chk($sformatf("%s.addr%0d", tag, c), 32'(rom_addr), 32'(base + c));
      end else begin
        chk($sformatf("%s.en%0d", tag, c),   32'(rom_en),   32'd0);
      end
      if (c >= 2) begin
        chk($sformatf("%s.valid%0d", tag, c), 32'(out_valid), 32'd1);
        chk($sformatf("%s.hit%0d", tag, c),   32'(out_hit),   32'd1);
        chk($sformatf("%s.color%0d", tag, c), 32'(out_color), 32'((base + c - 2) & 12'hFFF));
      end else begin
        chk($sformatf("%s.valid%0d", tag, c), 32'(out_valid), 32'd0);
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero($sformatf("%s.rst_now", tag));
        tick();
        chk_zero($sformatf("%s.rst_hold", tag));
        rst_n = 1'b1;
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    pend = 13'h0000; fixed_word = 13'h0123; use_pattern = 1'b0;
    rst_n = 1'b0; frame_start = 1'b0; sprite_x = 10'd0; sprite_y = 10'd0; anim_en = 1'b0;
    pix_valid = 1'b0; pix_x = 10'd0; pix_y = 10'd0; rom_data = 13'h0000;

    // 1. reset with random inputs, then pixel (0,0) hits with pos (0,0)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frame_start = 1'($urandom); sprite_x = 10'($urandom); sprite_y = 10'($urandom);
      anim_en = 1'($urandom); pix_valid = 1'($urandom); pix_x = 10'($urandom);
      pix_y = 10'($urandom); rom_data = 13'($urandom);
    end
    #1;
    chk_zero("reset");
    @(negedge clk);
    frame_start = 1'b0; anim_en = 1'b0; pix_valid = 1'b0; rom_data = 13'h0000;
    rst_n = 1'b1;
    pixel("origin", 1'b1, 0, 0, 1'b1, 0, 1'b1, 12'h123);

    // 2. hit path: corners of the box
    fstart(100, 50, 1'b0);
    fixed_word = 13'h0ABC;
    pixel("tl", 1'b1, 100, 50, 1'b1, 0, 1'b1, 12'hABC);
    pixel("br", 1'b1, 163, 113, 1'b1, 4095, 1'b1, 12'hABC);

    // 3. misses, invalid pixel, transparent word
    pixel("miss_r", 1'b1, 164, 50, 1'b0, 0, 1'b0, 0);
    pixel("miss_l", 1'b1, 99, 50, 1'b0, 0, 1'b0, 0);
    pixel("miss_b", 1'b1, 100, 114, 1'b0, 0, 1'b0, 0);
    pixel("novalid", 1'b0, 120, 60, 1'b0, 0, 1'b0, 0);
    fixed_word = 13'h1FFF;
    pixel("transp", 1'b1, 120, 60, 1'b1, 660, 1'b0, 0);
    fixed_word = 13'h0ABC;

    // 4. animation stepping, wrap and hold
    for (int i = 0; i < 6; i++) fstart(100, 50, 1'b1);
    pixel("anim6", 1'b1, 100, 50, 1'b1, 4096, 1'b1, 12'hABC);
    for (int i = 0; i < 6; i++) fstart(100, 50, 1'b1);
    pixel("anim12", 1'b1, 100, 50, 1'b1, 8192, 1'b1, 12'hABC);
    for (int i = 0; i < 36; i++) fstart(100, 50, 1'b1);
    pixel("anim48", 1'b1, 100, 50, 1'b1, 0, 1'b1, 12'hABC);
    for (int i = 0; i < 6; i++) fstart(100, 50, 1'b1);
    for (int i = 0; i < 10; i++) fstart(100, 50, 1'b0);
    pixel("anim_hold", 1'b1, 100, 50, 1'b1, 4096, 1'b1, 12'hABC);

    // frame_start coincident with a pixel: that pixel still sees the old position
    frame_start = 1'b1; sprite_x = 10'd300; sprite_y = 10'd300;
    pix_valid = 1'b1; pix_x = 10'd100; pix_y = 10'd50;
    tick();
    frame_start = 1'b0;
    chk("same_cyc.en", 32'(rom_en), 32'd1);
    chk("same_cyc.addr", 32'(rom_addr), 32'd4096);
    pixel("new_pos_old", 1'b1, 100, 50, 1'b0, 0, 1'b0, 0);
    pixel("new_pos", 1'b1, 301, 302, 1'b1, 4096 + 2 * 64 + 1, 1'b1, 12'hABC);

    // 5. right-edge clipping without wrap
    fstart(1000, 0, 1'b0);
    pixel("clip_1023", 1'b1, 1023, 0, 1'b1, 4096 + 23, 1'b1, 12'hABC);
    pixel("clip_row", 1'b1, 1023, 63, 1'b1, 4096 + 63 * 64 + 23, 1'b1, 12'hABC);
    pixel("clip_0", 1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
    pixel("clip_999", 1'b1, 999, 0, 1'b0, 0, 1'b0, 0);

    // 6. streaming, mid-stream reset, then a fresh stream after reset (frame back to 0)
    use_pattern = 1'b1;
    fstart(0, 0, 1'b0);
    stream("strm_a", 12, 4096 + 128, 7);
    stream("strm_b", 8, 128, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
